packed_array_access_ctrl: RTL and testbench

Controller that owns one descending 2D packed register array, logic [WA-1:0][WB-1:0], and shares it between two requesters. It round-robin arbitrates their requests and sequences slice-granular read, write and clear operations. Supported slices are whole array, lower or upper half of the elements, one element, the low or high half of one element, and a single bit. The full array contents are also exported directly for datapath consumers.

---
 rtl/packed_array_access_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_packed_array_access_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/packed_array_access_ctrl.sv
// packed_array_access_ctrl
// Owns a WA x WB packed register array and shares it between two requesters.
// Requests are round-robin arbitrated and executed as slice-granular read,
// write or clear operations, one operation every three cycles
// (IDLE -> EXEC -> RESP).
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   req_valid[r]   request valid from requester r
//   req_ready[r]   accept strobe to requester r (IDLE only, one-hot)
//   req_op         {op1, op0}: 0=read, 1=write, 2=clear, 3=illegal
//   req_mode       {mode1, mode0}: slice select, 7 is illegal
//   req_idx        {idx1, idx0}: element index
//   req_bidx       {bidx1, bidx0}: bit index within the element (mode 6)
//   req_wdata      {wdata1, wdata0}: right-aligned write data
//   rsp_valid      one-cycle response pulse
//   rsp_id         requester owning the response
//   rsp_err        illegal request; array untouched
//   rsp_rdata      right-aligned, zero-extended read data (held between reads)
//   array_q        live array contents
//   busy           operation in flight
module packed_array_access_ctrl #(
  parameter int unsigned WA = 8,
  parameter int unsigned WB = 8,
  parameter int unsigned IW = $clog2(WA),
  parameter int unsigned BW = $clog2(WB)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [3:0]            req_op,
  input  logic [5:0]            req_mode,
  input  logic [2*IW-1:0]       req_idx,
  input  logic [2*BW-1:0]       req_bidx,
  input  logic [2*WA*WB-1:0]    req_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_id,
  output logic                  rsp_err,
  output logic [WA*WB-1:0]      rsp_rdata,
  output logic [WA*WB-1:0]      array_q,
  output logic                  busy
);

  localparam int unsigned N  = WA * WB;
  localparam int unsigned H  = N / 2;
  localparam int unsigned HB = WB / 2;
  localparam int unsigned OW = IW + BW;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state;
  logic            last;
  logic            cur_id;
  logic [1:0]      cur_op;
  logic [2:0]      cur_mode;
  logic [IW-1:0]   cur_idx;
  logic [BW-1:0]   cur_bidx;
  logic [N-1:0]    cur_wdata;

  logic            any_req;
  logic            grant_id;
  logic [OW-1:0]   elem_base;
  logic [OW-1:0]   sl_off;
  logic [N-1:0]    sl_ones;
  logic [N-1:0]    sl_mask;
  logic [N-1:0]    wr_bits;
  logic [N-1:0]    rd_bits;
  logic            illegal;

  // Round-robin grant: on contention the requester not served last wins.
  always_comb begin
    any_req  = |req_valid;
    grant_id = 1'b0;
    if (req_valid == 2'b11) begin
      grant_id = ~last;
    end else if (req_valid[1]) begin
      grant_id = 1'b1;
    end
    req_ready = 2'b00;
    if ((state == IDLE) && any_req && !rst) begin
      req_ready = grant_id ? 2'b10 : 2'b01;
    end
  end

  // Slice decode: a right-aligned run of ones (slice width) and its bit offset.
  always_comb begin
    elem_base = {cur_idx, {BW{1'b0}}};
    sl_off    = '0;
    sl_ones   = '0;
    case (cur_mode)
      3'd0: sl_ones = '1;
      3'd1: sl_ones = N'({H{1'b1}});
      3'd2: begin
        sl_off  = OW'(H);
        sl_ones = N'({H{1'b1}});
      end
      3'd3: begin
        sl_off  = elem_base;
        sl_ones = N'({WB{1'b1}});
      end
      3'd4: begin
        sl_off  = elem_base;
        sl_ones = N'({HB{1'b1}});
      end
      3'd5: begin
        sl_off  = elem_base + OW'(HB);
        sl_ones = N'({HB{1'b1}});
      end
      3'd6: begin
        sl_off  = elem_base + OW'(cur_bidx);
        sl_ones = N'(1'b1);
      end
      default: ;
    endcase
    illegal = (cur_mode == 3'd7) || (cur_op == 2'd3);
    sl_mask = sl_ones << sl_off;
    wr_bits = (cur_wdata & sl_ones) << sl_off;
    rd_bits = (array_q >> sl_off) & sl_ones;
  end

  // Sequencer, request capture, array update and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      last      <= 1'b1;
      cur_id    <= 1'b0;
      cur_op    <= '0;
      cur_mode  <= '0;
      cur_idx   <= '0;
      cur_bidx  <= '0;
      cur_wdata <= '0;
      array_q   <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            cur_id    <= grant_id;
            last      <= grant_id;
            cur_op    <= grant_id ? req_op[3:2]          : req_op[1:0];
            cur_mode  <= grant_id ? req_mode[5:3]        : req_mode[2:0];
            cur_idx   <= grant_id ? req_idx[2*IW-1:IW]   : req_idx[IW-1:0];
            cur_bidx  <= grant_id ? req_bidx[2*BW-1:BW]  : req_bidx[BW-1:0];
            cur_wdata <= grant_id ? req_wdata[2*N-1:N]   : req_wdata[N-1:0];
            busy      <= 1'b1;
            state     <= EXEC;
          end
        end
        EXEC: begin
          if (!illegal) begin
            if (cur_op == 2'd1) begin
              array_q <= (array_q & ~sl_mask) | wr_bits;
            end else if (cur_op == 2'd2) begin
              array_q <= array_q & ~sl_mask;
            end
          end
          // rsp_rdata only moves on reads and illegal requests.
          if (illegal) begin
            rsp_rdata <= '0;
          end else if (cur_op == 2'd0) begin
            rsp_rdata <= rd_bits;
          end
          rsp_err   <= illegal;
          rsp_id    <= cur_id;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_packed_array_access_ctrl.sv
// Bench for packed_array_access_ctrl (WA = WB = 8): directed transactions with
// literal expectations plus a per-cycle reference model of array, grant and
// response behaviour.
module tb_packed_array_access_ctrl;

  localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   req_valid = '0;
  logic [1:0]   req_ready;
  logic [3:0]   req_op = '0;
  logic [5:0]   req_mode = '0;
  logic [5:0]   req_idx = '0;
  logic [5:0]   req_bidx = '0;
  logic [127:0] req_wdata = '0;
  logic         rsp_valid;
  logic         rsp_id;
  logic         rsp_err;
  logic [63:0]  rsp_rdata;
  logic [63:0]  array_q;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;

  packed_array_access_ctrl #(.WA(8), .WB(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_mode(req_mode), .req_idx(req_idx),
    .req_bidx(req_bidx), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_err(rsp_err),
    .rsp_rdata(rsp_rdata), .array_q(array_q), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Slice as (lowest bit, width) straight from the slice table.
  function automatic void slice_of(input logic [2:0] mode, input int idx, input int bidx,
                                   output int lo, output int w);
    lo = 0; w = 0;
    case (mode)
      3'd0: begin lo = 0;            w = 64; end
      3'd1: begin lo = 0;            w = 32; end
      3'd2: begin lo = 32;           w = 32; end
      3'd3: begin lo = 8*idx;        w = 8;  end
      3'd4: begin lo = 8*idx;        w = 4;  end
      3'd5: begin lo = 8*idx + 4;    w = 4;  end
      3'd6: begin lo = 8*idx + bidx; w = 1;  end
      default: begin lo = 0; w = 0; end
    endcase
  endfunction

  logic [63:0] m_arr;
  logic [63:0] m_rd;
  int          m_phase;   // 0 idle, 1 executing, 2 responding
  bit          m_last, m_id, m_err, m_chk_rd;
  logic [1:0]  m_op;
  logic [2:0]  m_mode;
  int          m_idx, m_bidx, c_lo, c_w, c_gi;
  logic [63:0] m_wd;
  logic [1:0]  c_exp_ready;

  always @(negedge clk) begin
    if (rst) begin
      check("rst_array_q", array_q, 64'd0);
      check("rst_req_ready", 64'(req_ready), 64'd0);
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_rsp_rdata", rsp_rdata, 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      m_arr = '0; m_rd = '0; m_phase = 0; m_last = 1'b1; m_id = 1'b0;
      m_err = 1'b0; m_chk_rd = 1'b0;
    end else begin
      c_gi = 0;
      if (req_valid == 2'b11) c_gi = m_last ? 0 : 1;
      else if (req_valid[1]) c_gi = 1;
      c_exp_ready = (m_phase == 0 && req_valid != 2'b00) ? (c_gi == 1 ? 2'b10 : 2'b01) : 2'b00;
      check("m_req_ready", 64'(req_ready), 64'(c_exp_ready));
      check("m_array_q", array_q, m_arr);
      check("m_busy", 64'(busy), 64'(m_phase != 0));
      check("m_rsp_valid", 64'(rsp_valid), 64'(m_phase == 2));
      if (m_phase == 2) begin
        check("m_rsp_id", 64'(rsp_id), 64'(m_id));
        check("m_rsp_err", 64'(rsp_err), 64'(m_err));
        if (m_chk_rd) check("m_rsp_rdata", rsp_rdata, m_rd);
      end
      case (m_phase)
        0: if (req_valid != 2'b00) begin
          m_last = (c_gi == 1);
          m_id   = (c_gi == 1);
          m_op   = req_op[c_gi*2 +: 2];
          m_mode = req_mode[c_gi*3 +: 3];
          m_idx  = int'(req_idx[c_gi*3 +: 3]);
          m_bidx = int'(req_bidx[c_gi*3 +: 3]);
          m_wd   = req_wdata[c_gi*64 +: 64];
          m_phase = 1;
        end
        1: begin
          slice_of(m_mode, m_idx, m_bidx, c_lo, c_w);
          m_err    = (m_mode == 3'd7) || (m_op == 2'd3);
          m_chk_rd = m_err || (m_op == 2'd0);
          if (m_err) m_rd = '0;
          else if (m_op == 2'd0) begin
            m_rd = '0;
            for (int b = 0; b < c_w; b++) m_rd[b] = m_arr[c_lo + b];
          end else begin
            for (int b = 0; b < c_w; b++) m_arr[c_lo + b] = (m_op == 2'd1) ? m_wd[b] : 1'b0;
          end
          m_phase = 2;
        end
        default: m_phase = 0;
      endcase
    end
  end

  // ---------------- directed stimulus ----------------
  // Issues one request from requester r, waits for accept and response.
  task automatic do_op(input int r, input logic [1:0] op, input logic [2:0] mode,
                       input int idx, input int bidx, input logic [63:0] wd,
                       output logic [63:0] rd, output logic err, output logic id);
    bit got;
    int lat;
    req_op[r*2 +: 2]    = op;
    req_mode[r*3 +: 3]  = mode;
    req_idx[r*3 +: 3]   = 3'(idx);
    req_bidx[r*3 +: 3]  = 3'(bidx);
    req_wdata[r*64 +: 64] = wd;
    req_valid[r] = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (req_ready[r]) got = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check("accept_seen", 64'(got), 64'd1);
    @(posedge clk); #1;
    req_valid[r] = 1'b0;
    got = 1'b0; lat = 0; rd = '0; err = 1'b0; id = 1'b0;
    for (int c = 1; c <= 4 && !got; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = 1'b1; lat = c; rd = rsp_rdata; err = rsp_err; id = rsp_id;
      end
    end
    check("rsp_latency", 64'(lat), 64'd2);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Both requesters hold valid until nops grants were seen.
  task automatic contention(input int nops);
    int order[8];
    int n;
    logic [1:0] prev;
    n = 0; prev = 2'b00;
    req_op = 4'b0000; req_mode = 6'd0;
    req_valid = 2'b11;
    for (int c = 0; c < 60 && n < nops; c++) begin
      @(negedge clk);
      check("ready_not_both", 64'(req_ready == 2'b11), 64'd0);
      check("ready_single_pulse", 64'(req_ready & prev), 64'd0);
      if (req_ready != 2'b00) begin
        order[n] = req_ready[1] ? 1 : 0;
        n++;
      end
      prev = req_ready;
      @(posedge clk); #1;
    end
    req_valid = 2'b00;
    check("contention_grants", 64'(n), 64'(nops));
    for (int i = 0; i < nops && i < n; i++)
      check($sformatf("grant_order_%0d", i), 64'(order[i]), 64'(i % 2));
    repeat (4) @(posedge clk);
    #1;
  endtask

  localparam logic [2:0]  SL_MODE [5] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6};
  localparam int          SL_IDX  [5] = '{0, 0, 0, 7, 7};
  localparam int          SL_BIDX [5] = '{0, 0, 0, 0, 7};
  localparam logic [63:0] SL_EXP  [5] = '{64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_0000_0000,
                                          64'h0000_0000_0000_00FF, 64'hF000_0000_0000_0000,
                                          64'h8000_0000_0000_0000};

  initial begin
    logic [63:0] rd;
    logic err, id;
    int n_pulse;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Full-array write then read, requester 0.
    do_op(0, 2'd1, 3'd0, 0, 0, ALL1, rd, err, id);
    check("t1_array", array_q, ALL1);
    do_op(0, 2'd0, 3'd0, 0, 0, 64'd0, rd, err, id);
    check("t1_rdata", rd, ALL1);
    check("t1_id", 64'(id), 64'd0);
    check("t1_err", 64'(err), 64'd0);

    // Slice writes on a cleared array.
    for (int i = 0; i < 5; i++) begin
      do_op(0, 2'd2, 3'd0, 0, 0, ALL1, rd, err, id);
      check("slice_pre_clear", array_q, 64'd0);
      do_op(0, 2'd1, SL_MODE[i], SL_IDX[i], SL_BIDX[i], ALL1, rd, err, id);
      check($sformatf("slice_write_m%0d", SL_MODE[i]), array_q, SL_EXP[i]);
    end

    // Requester 1: clear low nibble of element 0, read element 0.
    do_op(1, 2'd1, 3'd0, 0, 0, ALL1, rd, err, id);
    do_op(1, 2'd2, 3'd4, 0, 0, ALL1, rd, err, id);
    do_op(1, 2'd0, 3'd3, 0, 0, 64'd0, rd, err, id);
    check("r1_array", array_q, 64'hFFFF_FFFF_FFFF_FFF0);
    check("r1_rdata", rd, 64'h0000_0000_0000_00F0);
    check("r1_id", 64'(id), 64'd1);

    // Illegal requests leave the array alone.
    do_op(0, 2'd1, 3'd0, 0, 0, 64'h1234_5678_9ABC_DEF0, rd, err, id);
    do_op(0, 2'd1, 3'd7, 3, 0, ALL1, rd, err, id);
    check("ill_mode_err", 64'(err), 64'd1);
    check("ill_mode_rdata", rd, 64'd0);
    check("ill_mode_array", array_q, 64'h1234_5678_9ABC_DEF0);
    do_op(0, 2'd3, 3'd0, 0, 0, ALL1, rd, err, id);
    check("ill_op_err", 64'(err), 64'd1);
    check("ill_op_rdata", rd, 64'd0);
    check("ill_op_array", array_q, 64'h1234_5678_9ABC_DEF0);

    // Contention from reset.
    do_reset();
    contention(4);

    // Reset during EXEC of a full-array write.
    do_op(0, 2'd1, 3'd0, 0, 0, 64'h5555_5555_5555_5555, rd, err, id);
    req_op[1:0] = 2'd1; req_mode[2:0] = 3'd0; req_wdata[63:0] = ALL1;
    req_valid[0] = 1'b1;
    n_pulse = 0;
    for (int c = 0; c < 20 && n_pulse == 0; c++) begin
      @(negedge clk);
      if (req_ready[0]) n_pulse = 1;
      else begin @(posedge clk); #1; end
    end
    check("mid_rst_accept", 64'(n_pulse), 64'd1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    check("mid_rst_busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_array", array_q, 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n_pulse = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (rsp_valid) n_pulse++;
    end
    check("mid_rst_no_rsp", 64'(n_pulse), 64'd0);
    @(posedge clk); #1;
    contention(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
